apu_mode_counter: RTL and testbench

APU_MODE_COUNTER -- requirements
Module: apu_mode_counter

---
 rtl/apu_counter_pkg.sv | 13 +
 rtl/apu_mode_counter.sv | 110 +++++++++++
 tb/tb_apu_mode_counter.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/apu_counter_pkg.sv
// Shared definitions for the APU mode counter: default width and mode encodings.
package apu_counter_pkg;

  localparam int APU_CNT_WIDTH = 8;

  typedef enum logic [1:0] {
    UP_FREE    = 2'b00,
    DN_FREE    = 2'b01,
    DN_RELOAD  = 2'b10,
    DN_ONESHOT = 2'b11
  } apu_mode_e;

endpackage

// File: rtl/apu_mode_counter.sv
// Chainable up/down counter with free-run, auto-reload and one-shot modes.
// The terminal-count pulse is registered; cout and zero are combinational for chaining.
module apu_mode_counter
  import apu_counter_pkg::*;
#(
  parameter int WIDTH = APU_CNT_WIDTH
) (
  input  logic             CLK,
  input  logic             nRES,
  input  logic [1:0]       mode,
  input  logic             clear,
  input  logic             load,
  input  logic             wr_reload,
  input  logic [WIDTH-1:0] din,
  input  logic             step,
  input  logic             cin,
  output logic [WIDTH-1:0] q,
  output logic             cout,
  output logic             tc,
  output logic             zero
);

  localparam logic [WIDTH-1:0] ZERO_C = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONE_C  = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] ONES_C = {WIDTH{1'b1}};

  logic [WIDTH-1:0] q_r;
  logic [WIDTH-1:0] reload_r;
  logic             tc_r;
  logic [WIDTH-1:0] q_nxt_s;
  logic             tc_nxt_s;
  logic             es_s;
  logic             is_zero_s;
  logic             is_ones_s;
  apu_mode_e        mode_s;

  assign mode_s    = apu_mode_e'(mode);
  assign es_s      = step & cin;
  assign is_zero_s = (q_r == ZERO_C);
  assign is_ones_s = (q_r == ONES_C);

  // Next count and terminal-count decision; clear beats load beats counting.
  always_comb begin
    q_nxt_s  = q_r;
    tc_nxt_s = 1'b0;
    if (clear) begin
      q_nxt_s = ZERO_C;
    end else if (load) begin
      q_nxt_s = din;
    end else if (es_s) begin
      case (mode_s)
        UP_FREE: begin
          q_nxt_s  = q_r + ONE_C;
          tc_nxt_s = is_ones_s;
        end
        DN_FREE: begin
          q_nxt_s  = q_r - ONE_C;
          tc_nxt_s = is_zero_s;
        end
        DN_RELOAD: begin
          if (is_zero_s) begin
            // Uses the reload value held before any same-cycle write.
            q_nxt_s  = reload_r;
            tc_nxt_s = 1'b1;
          end else begin
            q_nxt_s  = q_r - ONE_C;
            tc_nxt_s = 1'b0;
          end
        end
        DN_ONESHOT: begin
          if (is_zero_s) begin
            q_nxt_s  = q_r;
            tc_nxt_s = 1'b0;
          end else begin
            q_nxt_s  = q_r - ONE_C;
            tc_nxt_s = (q_r == ONE_C);
          end
        end
        default: begin
          q_nxt_s  = q_r;
          tc_nxt_s = 1'b0;
        end
      endcase
    end else begin
      q_nxt_s  = q_r;
      tc_nxt_s = 1'b0;
    end
  end

  // Count, reload register and terminal-count pulse.
  always_ff @(posedge CLK or negedge nRES) begin
    if (!nRES) begin
      q_r      <= ZERO_C;
      reload_r <= ZERO_C;
      tc_r     <= 1'b0;
    end else begin
      q_r  <= q_nxt_s;
      tc_r <= tc_nxt_s;
      if (wr_reload) begin
        reload_r <= din;
      end
    end
  end

  assign q    = q_r;
  assign tc   = tc_r;
  assign zero = is_zero_s;
  assign cout = cin & ((mode_s == UP_FREE) ? is_ones_s : is_zero_s);

endmodule

// File: tb/tb_apu_mode_counter.sv
// Directed self-checking bench for apu_mode_counter (WIDTH=8) including a two-stage chain.
module tb_apu_mode_counter;

  logic       CLK = 1'b0;
  logic       nRES;
  logic [1:0] mode;
  logic       clear, load, wr_reload, step, cin;
  logic [7:0] din;
  logic [7:0] q;
  logic       cout, tc, zero;

  logic       ch_load, ch_step;
  logic [7:0] ch_din_lo, ch_din_hi;
  logic [7:0] q_lo, q_hi;
  logic       cout_lo, cout_hi, tc_lo, tc_hi, zero_lo, zero_hi;

  int errors = 0;
  int checks = 0;

  always #5 CLK = ~CLK;

  apu_mode_counter #(.WIDTH(8)) u_dut (
    .CLK(CLK), .nRES(nRES), .mode(mode), .clear(clear), .load(load),
    .wr_reload(wr_reload), .din(din), .step(step), .cin(cin),
    .q(q), .cout(cout), .tc(tc), .zero(zero)
  );

  apu_mode_counter #(.WIDTH(8)) u_lo (
    .CLK(CLK), .nRES(nRES), .mode(2'b00), .clear(1'b0), .load(ch_load),
    .wr_reload(1'b0), .din(ch_din_lo), .step(ch_step), .cin(1'b1),
    .q(q_lo), .cout(cout_lo), .tc(tc_lo), .zero(zero_lo)
  );

  apu_mode_counter #(.WIDTH(8)) u_hi (
    .CLK(CLK), .nRES(nRES), .mode(2'b00), .clear(1'b0), .load(ch_load),
    .wr_reload(1'b0), .din(ch_din_hi), .step(ch_step), .cin(cout_lo),
    .q(q_hi), .cout(cout_hi), .tc(tc_hi), .zero(zero_hi)
  );

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_inputs();
    clear = 1'b0; load = 1'b0; wr_reload = 1'b0; step = 1'b0; cin = 1'b1; din = 8'h00;
  endtask

  task automatic test_reset();
    nRES = 1'b0; mode = 2'b00; idle_inputs();
    ch_load = 1'b0; ch_step = 1'b0; ch_din_lo = 8'h00; ch_din_hi = 8'h00;
    #12;
    checks++; if (q !== 8'h00) begin errors++; $display("FAIL reset_q: got %h want %h", q, 8'h00); end
    checks++; if (tc !== 1'b0) begin errors++; $display("FAIL reset_tc: got %b want %b", tc, 1'b0); end
    checks++; if (zero !== 1'b1) begin errors++; $display("FAIL reset_zero: got %b want %b", zero, 1'b1); end
    checks++; if (cout !== 1'b0) begin errors++; $display("FAIL reset_cout: got %b want %b", cout, 1'b0); end
    @(negedge CLK);
    nRES = 1'b1;
    tick();
  endtask

  task automatic test_up_wrap();
    mode = 2'b00; load = 1'b1; din = 8'hFE;
    tick();
    checks++; if (q !== 8'hFE) begin errors++; $display("FAIL up_load: got %h want %h", q, 8'hFE); end
    checks++; if (cout !== 1'b0) begin errors++; $display("FAIL up_cout_fe: got %b want %b", cout, 1'b0); end
    load = 1'b0; step = 1'b1;
    tick();
    checks++; if (q !== 8'hFF) begin errors++; $display("FAIL up_q_ff: got %h want %h", q, 8'hFF); end
    checks++; if (tc !== 1'b0) begin errors++; $display("FAIL up_tc_ff: got %b want %b", tc, 1'b0); end
    checks++; if (cout !== 1'b1) begin errors++; $display("FAIL up_cout_ff: got %b want %b", cout, 1'b1); end
    tick();
    checks++; if (q !== 8'h00) begin errors++; $display("FAIL up_q_wrap: got %h want %h", q, 8'h00); end
    checks++; if (tc !== 1'b1) begin errors++; $display("FAIL up_tc_wrap: got %b want %b", tc, 1'b1); end
    checks++; if (cout !== 1'b0) begin errors++; $display("FAIL up_cout_00: got %b want %b", cout, 1'b0); end
    step = 1'b0;
    tick();
    checks++; if (tc !== 1'b0) begin errors++; $display("FAIL up_tc_drop: got %b want %b", tc, 1'b0); end
    checks++; if (q !== 8'h00) begin errors++; $display("FAIL up_hold: got %h want %h", q, 8'h00); end
  endtask

  task automatic test_reload();
    logic [7:0] exp_q [9];
    logic       exp_tc [9];
    int         pulses;
    exp_q  = '{8'h03, 8'h02, 8'h01, 8'h00, 8'h03, 8'h02, 8'h01, 8'h00, 8'h03};
    exp_tc = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    pulses = 0;
    mode = 2'b10; clear = 1'b1; wr_reload = 1'b1; din = 8'h03;
    tick();
    clear = 1'b0; wr_reload = 1'b0; step = 1'b1;
    for (int i = 0; i < 9; i++) begin
      tick();
      checks++; if (q !== exp_q[i]) begin errors++; $display("FAIL reload_q[%0d]: got %h want %h", i, q, exp_q[i]); end
      checks++; if (tc !== exp_tc[i]) begin errors++; $display("FAIL reload_tc[%0d]: got %b want %b", i, tc, exp_tc[i]); end
      if (i > 0 && tc === 1'b1) pulses++;
    end
    // Two reloads happen after the count has been run down from 3.
    checks++; if (pulses !== 2) begin errors++; $display("FAIL reload_pulses: got %0d want %0d", pulses, 2); end
    for (int i = 0; i < 3; i++) tick();
    checks++; if (q !== 8'h00) begin errors++; $display("FAIL reload_rundown: got %h want %h", q, 8'h00); end
    wr_reload = 1'b1; din = 8'h05;
    tick();
    checks++; if (q !== 8'h03) begin errors++; $display("FAIL reload_oldval: got %h want %h", q, 8'h03); end
    wr_reload = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    checks++; if (q !== 8'h05) begin errors++; $display("FAIL reload_newval: got %h want %h", q, 8'h05); end
    step = 1'b0;
  endtask

  task automatic test_oneshot();
    logic [7:0] exp_q [4];
    logic       exp_tc [4];
    logic       exp_z [4];
    exp_q  = '{8'h01, 8'h00, 8'h00, 8'h00};
    exp_tc = '{1'b0, 1'b1, 1'b0, 1'b0};
    exp_z  = '{1'b0, 1'b1, 1'b1, 1'b1};
    mode = 2'b11; load = 1'b1; din = 8'h02;
    tick();
    checks++; if (q !== 8'h02) begin errors++; $display("FAIL os_load: got %h want %h", q, 8'h02); end
    load = 1'b0; step = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++; if (q !== exp_q[i]) begin errors++; $display("FAIL os_q[%0d]: got %h want %h", i, q, exp_q[i]); end
      checks++; if (tc !== exp_tc[i]) begin errors++; $display("FAIL os_tc[%0d]: got %b want %b", i, tc, exp_tc[i]); end
      checks++; if (zero !== exp_z[i]) begin errors++; $display("FAIL os_zero[%0d]: got %b want %b", i, zero, exp_z[i]); end
    end
    step = 1'b0;
  endtask

  task automatic test_priority();
    mode = 2'b00; load = 1'b1; din = 8'h09;
    tick();
    clear = 1'b1; load = 1'b1; step = 1'b1; din = 8'h05;
    tick();
    checks++; if (q !== 8'h00) begin errors++; $display("FAIL prio_clear_q: got %h want %h", q, 8'h00); end
    checks++; if (tc !== 1'b0) begin errors++; $display("FAIL prio_clear_tc: got %b want %b", tc, 1'b0); end
    clear = 1'b0;
    tick();
    checks++; if (q !== 8'h05) begin errors++; $display("FAIL prio_load_q: got %h want %h", q, 8'h05); end
    checks++; if (tc !== 1'b0) begin errors++; $display("FAIL prio_load_tc: got %b want %b", tc, 1'b0); end
    load = 1'b0; step = 1'b0; mode = 2'b01; clear = 1'b1;
    tick();
    clear = 1'b0;
    #1;
    checks++; if (cout !== 1'b1) begin errors++; $display("FAIL dn_cout_zero: got %b want %b", cout, 1'b1); end
    cin = 1'b0;
    #1;
    checks++; if (cout !== 1'b0) begin errors++; $display("FAIL dn_cout_nocin: got %b want %b", cout, 1'b0); end
    step = 1'b1;
    tick();
    checks++; if (q !== 8'h00) begin errors++; $display("FAIL dn_no_cin_hold: got %h want %h", q, 8'h00); end
    cin = 1'b1;
    tick();
    checks++; if (q !== 8'hFF) begin errors++; $display("FAIL dn_wrap_q: got %h want %h", q, 8'hFF); end
    checks++; if (tc !== 1'b1) begin errors++; $display("FAIL dn_wrap_tc: got %b want %b", tc, 1'b1); end
    mode = 2'b00;
    tick();
    checks++; if (q !== 8'h00) begin errors++; $display("FAIL mode_switch_q: got %h want %h", q, 8'h00); end
    checks++; if (tc !== 1'b1) begin errors++; $display("FAIL mode_switch_tc: got %b want %b", tc, 1'b1); end
    step = 1'b0;
  endtask

  task automatic test_chain();
    ch_load = 1'b1; ch_din_lo = 8'hFF; ch_din_hi = 8'h00;
    tick();
    ch_load = 1'b0;
    checks++; if ({q_hi, q_lo} !== 16'h00FF) begin errors++; $display("FAIL chain_load: got %h want %h", {q_hi, q_lo}, 16'h00FF); end
    checks++; if (cout_lo !== 1'b1) begin errors++; $display("FAIL chain_cout_lo: got %b want %b", cout_lo, 1'b1); end
    ch_step = 1'b1;
    tick();
    ch_step = 1'b0;
    checks++; if ({q_hi, q_lo} !== 16'h0100) begin errors++; $display("FAIL chain_step: got %h want %h", {q_hi, q_lo}, 16'h0100); end
  endtask

  task automatic test_async_reset();
    mode = 2'b10; clear = 1'b1; wr_reload = 1'b1; din = 8'h07;
    tick();
    clear = 1'b0; wr_reload = 1'b0; step = 1'b1;
    tick();
    step = 1'b0;
    checks++; if (q !== 8'h07) begin errors++; $display("FAIL ares_pre_q: got %h want %h", q, 8'h07); end
    checks++; if (tc !== 1'b1) begin errors++; $display("FAIL ares_pre_tc: got %b want %b", tc, 1'b1); end
    #2;
    nRES = 1'b0;
    #1;
    checks++; if (q !== 8'h00) begin errors++; $display("FAIL ares_q: got %h want %h", q, 8'h00); end
    checks++; if (tc !== 1'b0) begin errors++; $display("FAIL ares_tc: got %b want %b", tc, 1'b0); end
    nRES = 1'b1;
    step = 1'b1;
    // Reload register was cleared too, so the reload from 0 yields 0.
    tick();
    step = 1'b0;
    checks++; if (q !== 8'h00) begin errors++; $display("FAIL ares_after_q: got %h want %h", q, 8'h00); end
    checks++; if (tc !== 1'b1) begin errors++; $display("FAIL ares_after_tc: got %b want %b", tc, 1'b1); end
  endtask

  initial begin
    test_reset();
    test_up_wrap();
    test_reload();
    test_oneshot();
    test_priority();
    test_chain();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
